biu_arbiter: RTL and testbench

Round-robin arbiter that shares one bus interface unit (BIU) master port between NUM_REQ requesters.
- Per cycle, selects one pending requester, issues its command to the BIU as a one-cycle en pulse, and tracks completion (read data or write retire).
- Returns a per-requester done/error pulse.
- Sits between multiple bus-mastering devices and the single BIU master-side device port.

---
 rtl/biu_arbiter_pkg.sv | 24 ++
 rtl/biu_arbiter_if.sv | 39 +++
 rtl/biu_arbiter_rr_priority_sel.sv | 47 ++++
 rtl/biu_arbiter.sv | 153 +++++++++++++++
 tb/tb_biu_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/biu_arbiter_pkg.sv
// Shared types and sizing helpers for the BIU round-robin arbiter.
package biu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Width of the WAIT-cycle counter; it must hold TIMEOUT_CYCLES-1.
    function automatic int cnt_width(input int timeout_cycles);
        if (timeout_cycles <= 0) begin
            return 1;
        end
        return $clog2(timeout_cycles + 1);
    endfunction

    // Width of a requester index (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/biu_arbiter_if.sv
// Bundle of requester-side and BIU-side signals around the arbiter.
// master: the arbiter's view; slave: the surrounding requesters + BIU.
interface biu_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic [NUM_REQ-1:0]            req_en;
    logic [NUM_REQ-1:0]            req_rnw;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_address;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_out;
    logic [NUM_REQ-1:0]            req_done;
    logic [NUM_REQ-1:0]            req_err;
    logic [DATA_WIDTH-1:0]         req_data_in;

    logic [ADDR_WIDTH-1:0]         biu_address;
    logic [DATA_WIDTH-1:0]         biu_data_out;
    logic                          biu_rnw;
    logic                          biu_en;
    logic [DATA_WIDTH-1:0]         biu_data_in;
    logic                          biu_data_valid;
    logic                          biu_busy;

    modport master (
        input  req_en, req_rnw, req_address, req_data_out,
        input  biu_data_in, biu_data_valid, biu_busy,
        output req_done, req_err, req_data_in,
        output biu_address, biu_data_out, biu_rnw, biu_en
    );

    modport slave (
        output req_en, req_rnw, req_address, req_data_out,
        output biu_data_in, biu_data_valid, biu_busy,
        input  req_done, req_err, req_data_in,
        input  biu_address, biu_data_out, biu_rnw, biu_en
    );

endinterface

// File: rtl/biu_arbiter_rr_priority_sel.sv
// Round-robin selector: first set request strictly after last_grant,
// wrapping around. Implemented as a priority encode over the requests
// above last_grant, falling back to the whole vector when none are above.
module rr_priority_sel
    import biu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [idx_width(NUM_REQ)-1:0]      last_grant,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [idx_width(NUM_REQ)-1:0]      idx,
    output logic                               valid
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0] above_mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pool;
    logic               found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bits
            assign above_mask[gi] = (IDX_W'(gi) > last_grant);
            assign grant[gi]      = valid && (idx == IDX_W'(gi));
        end
    endgenerate

    assign masked = req & above_mask;
    assign pool   = (|masked) ? masked : req;
    assign valid  = |req;

    // Lowest set bit of the candidate pool is the winner.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && pool[k]) begin
                found = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/biu_arbiter.sv
// Round-robin arbiter sharing one BIU master port between NUM_REQ
// requesters: grant, one-cycle en pulse, wait for read data / write
// retire (or timeout), then a one-cycle done/err pulse to the winner.
module biu_arbiter
    import biu_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          n_rst,
    biu_arbiter_if.master bus
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]     grant_oh_q, grant_oh_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  biu_address_q, biu_address_d;
    logic [DATA_WIDTH-1:0]  biu_data_out_q, biu_data_out_d;
    logic                   biu_rnw_q, biu_rnw_d;
    logic                   biu_en_q, biu_en_d;
    logic [NUM_REQ-1:0]     req_done_q, req_done_d;
    logic [NUM_REQ-1:0]     req_err_q, req_err_d;
    logic [DATA_WIDTH-1:0]  req_data_in_q, req_data_in_d;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

    logic [NUM_REQ-1:0]     sel_grant;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_valid;
    logic                   complete;
    logic                   timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = bus.req_data_out[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_priority_sel #(
        .NUM_REQ (NUM_REQ)
    ) u_sel (
        .req        (bus.req_en),
        .last_grant (last_grant_q),
        .grant      (sel_grant),
        .idx        (sel_idx),
        .valid      (sel_valid)
    );

    // Reads finish on the data strobe; writes finish when busy drops.
    assign complete    = biu_rnw_q ? bus.biu_data_valid : !bus.biu_busy;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_oh_d     = grant_oh_q;
        cnt_d          = cnt_q;
        biu_address_d  = biu_address_q;
        biu_data_out_d = biu_data_out_q;
        biu_rnw_d      = biu_rnw_q;
        biu_en_d       = 1'b0;
        req_done_d     = '0;
        req_err_d      = '0;
        req_data_in_d  = req_data_in_q;

        case (state_q)
            IDLE: begin
                if (sel_valid && !bus.biu_busy) begin
                    last_grant_d   = sel_idx;
                    grant_oh_d     = sel_grant;
                    biu_address_d  = addr_arr[sel_idx];
                    biu_data_out_d = wdata_arr[sel_idx];
                    biu_rnw_d      = bus.req_rnw[sel_idx];
                    biu_en_d       = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion takes precedence over a coincident timeout.
                if (complete || timeout_hit) begin
                    state_d    = DONE;
                    req_done_d = grant_oh_q;
                    req_err_d  = complete ? '0 : grant_oh_q;
                    if (complete && biu_rnw_q) begin
                        req_data_in_d = bus.biu_data_in;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            last_grant_q   <= IDX_W'(NUM_REQ - 1);
            grant_oh_q     <= '0;
            cnt_q          <= '0;
            biu_address_q  <= '0;
            biu_data_out_q <= '0;
            biu_rnw_q      <= 1'b0;
            biu_en_q       <= 1'b0;
            req_done_q     <= '0;
            req_err_q      <= '0;
            req_data_in_q  <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            grant_oh_q     <= grant_oh_d;
            cnt_q          <= cnt_d;
            biu_address_q  <= biu_address_d;
            biu_data_out_q <= biu_data_out_d;
            biu_rnw_q      <= biu_rnw_d;
            biu_en_q       <= biu_en_d;
            req_done_q     <= req_done_d;
            req_err_q      <= req_err_d;
            req_data_in_q  <= req_data_in_d;
        end
    end

    assign bus.biu_address  = biu_address_q;
    assign bus.biu_data_out = biu_data_out_q;
    assign bus.biu_rnw      = biu_rnw_q;
    assign bus.biu_en       = biu_en_q;
    assign bus.req_done     = req_done_q;
    assign bus.req_err      = req_err_q;
    assign bus.req_data_in  = req_data_in_q;

endmodule

// File: tb/tb_biu_arbiter.sv
// Bench for biu_arbiter: directed scenarios, a BIU responder, and a
// cycle-timeline model of the arbiter checked against the DUT each cycle.
module tb_biu_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    biu_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    biu_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle index; stable from just after each rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Event logs filled by the monitor, inspected by the directed tests.
    int          en_cyc_q[$];
    logic [31:0] en_addr_q[$];
    int          done_cyc_q[$];
    logic [3:0]  done_vec_q[$];
    logic [3:0]  done_err_q[$];
    logic [31:0] done_data_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        en_cyc_q.delete();
        en_addr_q.delete();
        done_cyc_q.delete();
        done_vec_q.delete();
        done_err_q.delete();
        done_data_q.delete();
    endtask

    task automatic set_req(input int i, input bit rnw, input logic [31:0] a, input logic [31:0] d);
        bus.req_en[i]                = 1'b1;
        bus.req_rnw[i]               = rnw;
        bus.req_address[i*AW +: AW]  = a;
        bus.req_data_out[i*DW +: DW] = d;
    endtask

    task automatic clr_req(input int i);
        bus.req_en[i] = 1'b0;
    endtask

    // Wait (bounded) until requester i sees its done pulse.
    task automatic wait_done(input int i, input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            tick();
            n++;
            if (bus.req_done[i]) seen = 1'b1;
        end
        chk($sformatf("wait_done_%0d", i), 64'(seen), 64'd1);
    endtask

    // Wait (bounded) until cnt done pulses of any requester have been seen.
    task automatic wait_ndone(input int cnt, input int budget);
        int n = 0;
        int seen = 0;
        while (seen < cnt && n < budget) begin
            tick();
            n++;
            if (|bus.req_done) seen++;
        end
        chk("wait_ndone", 64'(seen), 64'(cnt));
    endtask

    // ---------------- BIU responder ----------------
    int          rd_lat     = 3;
    int          wr_ret     = 2;
    bit          hang       = 1'b0;
    bit          busy_force = 1'b0;
    logic [31:0] rd_value   = 32'h0;
    int          r_en_c     = 0;
    bit          r_active   = 1'b0;
    bit          r_rnw      = 1'b0;
    bit          r_b, r_dv;

    initial begin
        bus.biu_busy       = 1'b0;
        bus.biu_data_valid = 1'b0;
        bus.biu_data_in    = '0;
        forever begin
            @(posedge clk);
            #2;
            r_b  = 1'b0;
            r_dv = 1'b0;
            if (!n_rst) begin
                r_active = 1'b0;
            end else begin
                if (bus.biu_en) begin
                    r_active = 1'b1;
                    r_en_c   = cyc;
                    r_rnw    = bus.biu_rnw;
                end
                if (r_active && !hang && cyc > r_en_c) begin
                    if (r_rnw) begin
                        r_b  = (cyc <= r_en_c + rd_lat);
                        r_dv = (cyc == r_en_c + rd_lat);
                    end else begin
                        r_b = (cyc <= r_en_c + wr_ret);
                    end
                end
            end
            bus.biu_busy       = busy_force | r_b;
            bus.biu_data_valid = r_dv;
            bus.biu_data_in    = r_dv ? rd_value : ~rd_value;
        end
    end

    // ---------------- timeline model + per-cycle compare ----------------
    logic        e_en, e_rnw, e_chk_data;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_done, e_err;
    int          m_last, m_e, m_free, m_g, w, c2;
    bit          m_active, m_rnw, comp, tmo, fnd;

    initial begin
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                chk("rst_biu_en",   64'(bus.biu_en),       64'd0);
                chk("rst_biu_addr", 64'(bus.biu_address),  64'd0);
                chk("rst_req_done", 64'(bus.req_done),     64'd0);
                chk("rst_req_err",  64'(bus.req_err),      64'd0);
                chk("rst_data_in",  64'(bus.req_data_in),  64'd0);
                e_en = 1'b0; e_rnw = 1'b0; e_chk_data = 1'b0;
                e_addr = '0; e_wdata = '0; e_data = '0;
                e_done = '0; e_err = '0;
                m_last = NR - 1; m_active = 1'b0; m_free = 0; m_g = 0; m_e = 0;
            end else begin
                chk("biu_en",       64'(bus.biu_en),       64'(e_en));
                chk("biu_address",  64'(bus.biu_address),  64'(e_addr));
                chk("biu_data_out", 64'(bus.biu_data_out), 64'(e_wdata));
                chk("biu_rnw",      64'(bus.biu_rnw),      64'(e_rnw));
                chk("req_done",     64'(bus.req_done),     64'(e_done));
                chk("req_err",      64'(bus.req_err),      64'(e_err));
                if (e_chk_data) chk("req_data_in", 64'(bus.req_data_in), 64'(e_data));

                if (bus.biu_en) begin
                    en_cyc_q.push_back(cyc);
                    en_addr_q.push_back(bus.biu_address);
                end
                if (|bus.req_done) begin
                    done_cyc_q.push_back(cyc);
                    done_vec_q.push_back(bus.req_done);
                    done_err_q.push_back(bus.req_err);
                    done_data_q.push_back(bus.req_data_in);
                end

                // Predict the registered outputs of the next cycle.
                e_en = 1'b0; e_done = '0; e_err = '0; e_chk_data = 1'b0;
                if (m_active) begin
                    if (cyc > m_e) begin
                        w    = cyc - m_e - 1;
                        comp = m_rnw ? bus.biu_data_valid : !bus.biu_busy;
                        tmo  = (w == TO - 1);
                        if (comp || tmo) begin
                            e_done[m_g] = 1'b1;
                            e_err[m_g]  = !comp;
                            if (comp && m_rnw) begin
                                e_data     = bus.biu_data_in;
                                e_chk_data = 1'b1;
                            end
                            m_active = 1'b0;
                            m_free   = cyc + 2;
                        end
                    end
                end else if (cyc >= m_free && (|bus.req_en) && !bus.biu_busy) begin
                    fnd = 1'b0;
                    for (int k = 1; k <= NR; k++) begin
                        c2 = (m_last + k) % NR;
                        if (!fnd && bus.req_en[c2]) begin
                            fnd = 1'b1;
                            m_g = c2;
                        end
                    end
                    m_last   = m_g;
                    m_active = 1'b1;
                    m_e      = cyc + 1;
                    m_rnw    = bus.req_rnw[m_g];
                    e_rnw    = m_rnw;
                    e_addr   = bus.req_address[m_g*AW +: AW];
                    e_wdata  = bus.req_data_out[m_g*DW +: DW];
                    e_en     = 1'b1;
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    int c0, f, n;

    initial begin
        bus.req_en       = '0;
        bus.req_rnw      = '0;
        bus.req_address  = '0;
        bus.req_data_out = '0;
        idle(3);
        n_rst = 1'b1;
        tick();

        // Single read from requester 1, data 3 cycles after en.
        clear_logs();
        rd_lat   = 3;
        rd_value = 32'hDEADBEEF;
        c0 = cyc;
        set_req(1, 1'b1, 32'h0000_1000, 32'h0);
        wait_done(1, 40);
        tick();
        clr_req(1);
        idle(4);
        chk("t1_en_count", 64'(en_cyc_q.size()), 64'd1);
        if (en_cyc_q.size() >= 1 && done_cyc_q.size() >= 1) begin
            chk("t1_en_cycle", 64'(en_cyc_q[0]), 64'(c0 + 1));
            chk("t1_en_addr",  64'(en_addr_q[0]), 64'h1000);
            chk("t1_latency",  64'(done_cyc_q[0] - en_cyc_q[0]), 64'd4);
            chk("t1_done_vec", 64'(done_vec_q[0]), 64'b0010);
            chk("t1_err_vec",  64'(done_err_q[0]), 64'd0);
            chk("t1_data",     64'(done_data_q[0]), 64'hDEADBEEF);
        end

        // Round robin over four held write requests after a fresh reset.
        n_rst = 1'b0;
        idle(2);
        n_rst = 1'b1;
        tick();
        clear_logs();
        wr_ret = 2;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h2000 + 32'(i) * 32'h10, 32'hA000 + 32'(i));
        wait_ndone(5, 150);
        tick();
        for (int i = 0; i < NR; i++) clr_req(i);
        idle(4);
        chk("t2_en_count", 64'(en_cyc_q.size()), 64'd5);
        if (en_cyc_q.size() >= 5 && done_cyc_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t2_order_%0d", i), 64'(done_vec_q[i]), 64'(4'b0001 << (i % 4)));
                chk($sformatf("t2_addr_%0d", i), 64'(en_addr_q[i]), 64'(32'h2000 + 32'(i % 4) * 32'h10));
            end
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t2_gap_%0d", i), 64'(en_cyc_q[i+1] - done_cyc_q[i]), 64'd2);
            end
        end

        // Busy gate: no grant while the BIU reports busy in IDLE.
        clear_logs();
        busy_force = 1'b1;
        set_req(0, 1'b0, 32'h3000, 32'h55);
        idle(6);
        chk("t3_no_en_busy", 64'(en_cyc_q.size()), 64'd0);
        busy_force = 1'b0;
        f = cyc;
        wait_done(0, 40);
        tick();
        clr_req(0);
        idle(4);
        if (en_cyc_q.size() >= 1 && done_vec_q.size() >= 1) begin
            chk("t3_en_cycle", 64'(en_cyc_q[0]), 64'(f + 1));
            chk("t3_done_vec", 64'(done_vec_q[0]), 64'b0001);
        end

        // Timeout on a read that never answers, then a normal write.
        clear_logs();
        hang = 1'b1;
        set_req(2, 1'b1, 32'h4000, 32'h0);
        wait_done(2, 40);
        tick();
        clr_req(2);
        hang = 1'b0;
        set_req(2, 1'b0, 32'h4100, 32'h77);
        wait_done(2, 40);
        tick();
        clr_req(2);
        idle(4);
        chk("t4_done_count", 64'(done_cyc_q.size()), 64'd2);
        if (en_cyc_q.size() >= 2 && done_cyc_q.size() >= 2) begin
            chk("t4_to_latency", 64'(done_cyc_q[0] - en_cyc_q[0]), 64'd9);
            chk("t4_to_err",     64'(done_err_q[0]), 64'b0100);
            chk("t4_to_done",    64'(done_vec_q[0]), 64'b0100);
            chk("t4_next_err",   64'(done_err_q[1]), 64'd0);
            chk("t4_next_addr",  64'(en_addr_q[1]), 64'h4100);
        end

        // Reset in the middle of a WAIT: outputs clear at once, no done.
        clear_logs();
        hang = 1'b1;
        set_req(1, 1'b1, 32'h5000, 32'h0);
        n = 0;
        while (!bus.biu_en && n < 20) begin
            tick();
            n++;
        end
        chk("t5_en_seen", 64'(bus.biu_en), 64'd1);
        idle(3);
        #2;
        n_rst = 1'b0;
        #1;
        chk("t5_rst_addr", 64'(bus.biu_address),  64'd0);
        chk("t5_rst_rnw",  64'(bus.biu_rnw),      64'd0);
        chk("t5_rst_done", 64'(bus.req_done),     64'd0);
        clr_req(1);
        hang = 1'b0;
        idle(2);
        chk("t5_no_done", 64'(done_cyc_q.size()), 64'd0);
        clear_logs();
        rd_lat   = 3;
        rd_value = 32'hCAFE0001;
        n_rst = 1'b1;
        set_req(0, 1'b1, 32'h6000, 32'h0);
        set_req(3, 1'b1, 32'h6300, 32'h0);
        wait_done(0, 40);
        tick();
        clr_req(0);
        wait_done(3, 40);
        tick();
        clr_req(3);
        idle(4);
        if (en_addr_q.size() >= 2 && done_vec_q.size() >= 2) begin
            chk("t5_first_addr", 64'(en_addr_q[0]), 64'h6000);
            chk("t5_first_vec",  64'(done_vec_q[0]), 64'b0001);
            chk("t5_second_vec", 64'(done_vec_q[1]), 64'b1000);
        end

        // Data strobe on the very cycle the timeout would fire.
        clear_logs();
        rd_lat   = TO;
        rd_value = 32'h12345678;
        set_req(3, 1'b1, 32'h7000, 32'h0);
        wait_done(3, 40);
        tick();
        clr_req(3);
        idle(4);
        if (en_cyc_q.size() >= 1 && done_cyc_q.size() >= 1) begin
            chk("t6_latency", 64'(done_cyc_q[0] - en_cyc_q[0]), 64'd9);
            chk("t6_err",     64'(done_err_q[0]), 64'd0);
            chk("t6_vec",     64'(done_vec_q[0]), 64'b1000);
            chk("t6_data",    64'(done_data_q[0]), 64'h12345678);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
